// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store sequencer for a req/gnt/rvalid data memory.
// Handles lane steering, load extension, legality checks and access timeout.
module mem_access_ctrl #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    input  logic                  RE_i,
    input  logic                  WE_i,
    input  logic [2:0]            funct3_i,
    input  logic [DATA_WIDTH-1:0] address_i,
    input  logic [DATA_WIDTH-1:0] write_data_i,
    output logic                  dmem_req_o,
    output logic                  dmem_we_o,
    output logic [DATA_WIDTH-1:0] dmem_addr_o,
    output logic [DATA_WIDTH-1:0] dmem_wdata_o,
    output logic [3:0]            dmem_be_o,
    input  logic                  dmem_gnt_i,
    input  logic                  dmem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] dmem_rdata_i,
    output logic                  stall_o,
    output logic [DATA_WIDTH-1:0] LMD_o,
    output logic                  lmd_valid_o,
    output logic [1:0]            err_o
);
    localparam int unsigned    CntW    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {StIdle, StReq, StWait, StDone, StErr} state_e;

    state_e                state_q;
    logic [CntW-1:0]       cnt_q;
    logic [DATA_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] lmd_q;
    logic [2:0]            funct3_q;
    logic                  store_q;
    logic [1:0]            err_q;

    logic                  access;
    logic                  f3_ok;
    logic                  illegal;
    logic                  misaligned;
    logic                  timeout;
    logic                  in_req;
    logic [DATA_WIDTH-1:0] rdata_shift;
    logic [DATA_WIDTH-1:0] load_fmt;
    logic [DATA_WIDTH-1:0] store_rep;
    logic [3:0]            store_be;

    assign access     = valid_i & (RE_i | WE_i);
    assign f3_ok      = RE_i ? (funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
                             : (funct3_i inside {3'b000, 3'b001, 3'b010});
    assign illegal    = (RE_i & WE_i) | ~f3_ok;
    assign misaligned = ((funct3_i[1:0] == 2'b01) & address_i[0]) |
                        ((funct3_i[1:0] == 2'b10) & (|address_i[1:0]));
    assign timeout    = (cnt_q == CntLast);
    assign in_req     = (state_q == StReq);

    // Halfword loads are aligned, so the byte-offset shift also selects the half lane.
    assign rdata_shift = dmem_rdata_i >> {addr_q[1:0], 3'b000};

    always_comb begin
        case (funct3_q[1:0])
            2'b00:   load_fmt = {{24{~funct3_q[2] & rdata_shift[7]}}, rdata_shift[7:0]};
            2'b01:   load_fmt = {{16{~funct3_q[2] & rdata_shift[15]}}, rdata_shift[15:0]};
            default: load_fmt = dmem_rdata_i;
        endcase
    end

    always_comb begin
        case (funct3_q[1:0])
            2'b00: begin
                store_be  = 4'b0001 << addr_q[1:0];
                store_rep = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                store_be  = addr_q[1] ? 4'b1100 : 4'b0011;
                store_rep = {2{wdata_q[15:0]}};
            end
            default: begin
                store_be  = 4'b1111;
                store_rep = wdata_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            funct3_q <= '0;
            store_q  <= 1'b0;
            err_q    <= 2'b00;
            lmd_q    <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    cnt_q <= '0;
                    if (access) begin
                        addr_q   <= address_i;
                        wdata_q  <= write_data_i;
                        funct3_q <= funct3_i;
                        store_q  <= WE_i;
                        if (illegal) begin
                            err_q   <= 2'b11;
                            state_q <= StErr;
                        end else if (misaligned) begin
                            err_q   <= 2'b01;
                            state_q <= StErr;
                        end else begin
                            state_q <= StReq;
                        end
                    end
                end
                StReq: begin
                    cnt_q <= cnt_q + 1'b1;
                    // A granted store completes even on the last budgeted cycle.
                    if (dmem_gnt_i && store_q) begin
                        state_q <= StDone;
                    end else if (timeout) begin
                        err_q   <= 2'b10;
                        state_q <= StErr;
                    end else if (dmem_gnt_i) begin
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (dmem_rvalid_i) begin
                        lmd_q   <= load_fmt;
                        state_q <= StDone;
                    end else if (timeout) begin
                        err_q   <= 2'b10;
                        state_q <= StErr;
                    end
                end
                default: begin
                    cnt_q   <= '0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign dmem_req_o   = in_req;
    assign dmem_we_o    = in_req & store_q;
    assign dmem_addr_o  = in_req ? {addr_q[DATA_WIDTH-1:2], 2'b00} : '0;
    assign dmem_be_o    = in_req ? (store_q ? store_be : 4'b1111) : 4'b0000;
    assign dmem_wdata_o = (in_req & store_q) ? store_rep : '0;
    assign stall_o      = ((state_q == StIdle) & access) | in_req | (state_q == StWait);
    assign LMD_o        = lmd_q;
    assign lmd_valid_o  = (state_q == StDone) & ~store_q;
    assign err_o        = (state_q == StErr) ? err_q : 2'b00;

endmodule
